// File: rtl/sr_ram_arb.sv
// sr_ram_arb: arbitrates PORTS requesters onto one synchronous-read RAM; round-robin by default,
// fixed priority (port 0 highest) when SR_RAM_ARB_PRIO_EN is defined.
module sr_ram_arb #(
  parameter int PORTS = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            req_valid,
  input  logic [PORTS-1:0]            req_we,
  input  logic [PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [PORTS*32-1:0]         req_wdata,
  output logic [PORTS-1:0]            req_ready,
  output logic [PORTS-1:0]            resp_valid,
  output logic [31:0]                 resp_rdata,
  output logic [ADDR_WIDTH-1:0]       ramAddress,
  output logic [31:0]                 wrData,
  output logic                        we,
  input  logic [31:0]                 rdData
);
  localparam logic [1:0] IDLE = 2'd0, RD_ADDR = 2'd1, RD_DATA = 2'd2;
  localparam int PW = PORTS > 2 ? 2 : 1;
  logic [1:0] state_q, state_d;
  logic [PW-1:0] win, port_q, port_d;
  logic found, accept;
  int start;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [31:0] wr_data_q, wr_data_d, resp_rdata_q, resp_rdata_d;
  logic we_q, we_d;
  logic [PORTS-1:0] resp_valid_q, resp_valid_d;
`ifndef SR_RAM_ARB_PRIO_EN
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  assign start = int'(rr_ptr_q);
  always_comb rr_ptr_d = accept ? PW'((int'(win) + 1) % PORTS) : rr_ptr_q;
  always_ff @(posedge clk) rr_ptr_q <= rst ? '0 : rr_ptr_d;
`else
  assign start = 0;
`endif
  // first asserted request found while scanning upward from start, wrapping at PORTS
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (!found && req_valid[(start + k) % PORTS]) begin
        found = 1'b1;
        win = PW'((start + k) % PORTS);
      end
    end
  end
  assign accept = found && state_q == IDLE && !rst;
  assign req_ready = accept ? (PORTS'(1) << win) : '0;
  always_comb begin
    state_d = state_q == RD_ADDR ? RD_DATA :
              state_q == RD_DATA ? IDLE :
              (accept && !req_we[win]) ? RD_ADDR : IDLE;
    port_d = accept ? win : port_q;
    ram_address_d = accept ? req_addr[win*ADDR_WIDTH +: ADDR_WIDTH] : ram_address_q;
    wr_data_d = (accept && req_we[win]) ? req_wdata[win*32 +: 32] : wr_data_q;
    we_d = accept && req_we[win];
    resp_valid_d = state_q == RD_DATA ? (PORTS'(1) << port_q) : '0;
    resp_rdata_d = state_q == RD_DATA ? rdData : resp_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      port_q <= '0;
      ram_address_q <= '0;
      wr_data_q <= '0;
      we_q <= 1'b0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      port_q <= port_d;
      ram_address_q <= ram_address_d;
      wr_data_q <= wr_data_d;
      we_q <= we_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end
  assign ramAddress = ram_address_q;
  assign wrData = wr_data_q;
  assign we = we_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_sr_ram_arb.sv
// tb_sr_ram_arb: table-driven check of sr_ram_arb (PORTS=2) against a RAM model, plus reset-mid-read
// and a PORTS=3 pointer-wrap sequence.
module tb_sr_ram_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] v = '0, w = '0;
  logic [63:0] a = '0, d = '0;
  logic [1:0] ready, rv;
  logic [31:0] rdata, ram_addr, wdata, rd_data;
  logic ram_we;
  logic [2:0] v3 = '0, ready3, rv3;
  logic [95:0] a3 = '0, d3 = '0;
  logic [31:0] rdata3, ram_addr3, wdata3;
  logic ram_we3;
  logic [31:0] mem [256];
  int checks = 0, passes = 0;

  sr_ram_arb #(.PORTS(2), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(v), .req_we(w), .req_addr(a), .req_wdata(d),
    .req_ready(ready), .resp_valid(rv), .resp_rdata(rdata), .ramAddress(ram_addr),
    .wrData(wdata), .we(ram_we), .rdData(rd_data));

  sr_ram_arb #(.PORTS(3), .ADDR_WIDTH(32)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_we(3'b111), .req_addr(a3), .req_wdata(d3),
    .req_ready(ready3), .resp_valid(rv3), .resp_rdata(rdata3), .ramAddress(ram_addr3),
    .wrData(wdata3), .we(ram_we3), .rdData(32'h0));

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= wdata;
    rd_data <= mem[ram_addr[7:0]];
  end

  typedef struct {
    logic [1:0] v, w;
    logic [7:0] a0, a1;
    logic [31:0] d0, d1;
    logic [1:0] er;
    logic ew;
    logic [7:0] ea;
    logic [31:0] ed;
    logic [1:0] erv;
    logic [31:0] erd;
  } vec_t;
  vec_t vecs [24];

  localparam logic [31:0] Z = 32'h0, D = 32'hDEADBEEF, C = 32'h12345678;
  localparam logic [31:0] A0 = 32'hA0, A1 = 32'hA1, ONE = 32'h1, TWO = 32'h2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{2'b10, 2'b10, 8'h00, 8'h10, Z,  D,   2'b10, 1'b0, 8'h00, Z,   2'b00, Z};
    vecs[1]  = '{2'b00, 2'b00, 8'h00, 8'h00, Z,  Z,   2'b00, 1'b1, 8'h10, D,   2'b00, Z};
    vecs[2]  = '{2'b01, 2'b01, 8'h04, 8'h00, C,  Z,   2'b01, 1'b0, 8'h10, D,   2'b00, Z};
    vecs[3]  = '{2'b10, 2'b10, 8'h00, 8'h08, Z,  ONE, 2'b10, 1'b1, 8'h04, C,   2'b00, Z};
    vecs[4]  = '{2'b01, 2'b00, 8'h04, 8'h00, Z,  Z,   2'b01, 1'b1, 8'h08, ONE, 2'b00, Z};
    vecs[5]  = '{2'b01, 2'b00, 8'h10, 8'h00, Z,  Z,   2'b00, 1'b0, 8'h04, ONE, 2'b00, Z};
    vecs[6]  = '{2'b01, 2'b00, 8'h10, 8'h00, Z,  Z,   2'b00, 1'b0, 8'h04, ONE, 2'b00, Z};
    vecs[7]  = '{2'b01, 2'b00, 8'h10, 8'h00, Z,  Z,   2'b01, 1'b0, 8'h04, ONE, 2'b01, C};
    vecs[8]  = '{2'b00, 2'b00, 8'h00, 8'h00, Z,  Z,   2'b00, 1'b0, 8'h10, ONE, 2'b00, C};
    vecs[9]  = '{2'b00, 2'b00, 8'h00, 8'h00, Z,  Z,   2'b00, 1'b0, 8'h10, ONE, 2'b00, C};
    vecs[10] = '{2'b01, 2'b00, 8'h08, 8'h00, Z,  Z,   2'b01, 1'b0, 8'h10, ONE, 2'b01, D};
    vecs[11] = '{2'b10, 2'b10, 8'h00, 8'h08, Z,  TWO, 2'b00, 1'b0, 8'h08, ONE, 2'b00, D};
    vecs[12] = '{2'b10, 2'b10, 8'h00, 8'h08, Z,  TWO, 2'b00, 1'b0, 8'h08, ONE, 2'b00, D};
    vecs[13] = '{2'b10, 2'b10, 8'h00, 8'h08, Z,  TWO, 2'b10, 1'b0, 8'h08, ONE, 2'b01, ONE};
    vecs[14] = '{2'b00, 2'b00, 8'h00, 8'h00, Z,  Z,   2'b00, 1'b1, 8'h08, TWO, 2'b00, ONE};
    vecs[15] = '{2'b11, 2'b11, 8'h20, 8'h21, A0, A1,  2'b01, 1'b0, 8'h08, TWO, 2'b00, ONE};
    vecs[16] = '{2'b11, 2'b11, 8'h20, 8'h21, A0, A1,  2'b10, 1'b1, 8'h20, A0,  2'b00, ONE};
    vecs[17] = '{2'b11, 2'b11, 8'h20, 8'h21, A0, A1,  2'b01, 1'b1, 8'h21, A1,  2'b00, ONE};
    vecs[18] = '{2'b11, 2'b11, 8'h20, 8'h21, A0, A1,  2'b10, 1'b1, 8'h20, A0,  2'b00, ONE};
    vecs[19] = '{2'b00, 2'b00, 8'h00, 8'h00, Z,  Z,   2'b00, 1'b1, 8'h21, A1,  2'b00, ONE};
    vecs[20] = '{2'b01, 2'b00, 8'h10, 8'h00, Z,  Z,   2'b01, 1'b0, 8'h21, A1,  2'b00, ONE};
    vecs[21] = '{2'b00, 2'b00, 8'h00, 8'h00, Z,  Z,   2'b00, 1'b0, 8'h10, A1,  2'b00, ONE};
    vecs[22] = '{2'b00, 2'b00, 8'h00, 8'h00, Z,  Z,   2'b00, 1'b0, 8'h10, A1,  2'b00, ONE};
    vecs[23] = '{2'b00, 2'b00, 8'h00, 8'h00, Z,  Z,   2'b00, 1'b0, 8'h10, A1,  2'b01, D};

    v = 2'b11;
    w = 2'b11;
    step();
    step();
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_we", 32'(ram_we), 32'h0);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_resp_valid", 32'(rv), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    v = '0;
    w = '0;

    for (int i = 0; i < 24; i++) begin
      step();
      v = vecs[i].v;
      w = vecs[i].w;
      a = {24'h0, vecs[i].a1, 24'h0, vecs[i].a0};
      d = {vecs[i].d1, vecs[i].d0};
      #1;
      chk($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].er));
      chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(vecs[i].ew));
      chk($sformatf("v%0d_addr", i), ram_addr, 32'(vecs[i].ea));
      chk($sformatf("v%0d_wdata", i), wdata, vecs[i].ed);
      chk($sformatf("v%0d_resp_valid", i), 32'(rv), 32'(vecs[i].erv));
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].erd);
    end

    // reset during RD_DATA: read is dropped and the pointer returns to port 0
    step();
    v = 2'b01;
    w = 2'b00;
    a = {32'h0, 32'h04};
    d = {32'h66, 32'h55};
    #1;
    chk("mr_accept", 32'(ready), 32'h1);
    step();
    chk("mr_rd_addr_ready", 32'(ready), 32'h0);
    step();
    rst = 1'b1;
    v = 2'b11;
    w = 2'b11;
    #1;
    chk("mr_rst_ready", 32'(ready), 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("mr_resp_valid", 32'(rv), 32'h0);
    chk("mr_addr", ram_addr, 32'h0);
    chk("mr_rdata", rdata, 32'h0);
    chk("mr_grant", 32'(ready), 32'h1);
    step();
    v = '0;
    #1;
    chk("mr_resp_valid2", 32'(rv), 32'h0);
    chk("mr_we", 32'(ram_we), 32'h1);
    chk("mr_wdata", wdata, 32'h55);

    // PORTS=3 round-robin wrap
    step();
    v3 = 3'b111;
    a3 = {32'h32, 32'h31, 32'h30};
    d3 = {32'hC2, 32'hC1, 32'hC0};
    #1;
    chk("wrap0", 32'(ready3), 32'h1);
    step();
    chk("wrap1", 32'(ready3), 32'h2);
    chk("wrap1_addr", ram_addr3, 32'h30);
    step();
    chk("wrap2", 32'(ready3), 32'h4);
    chk("wrap2_wdata", wdata3, 32'hC1);
    step();
    chk("wrap3", 32'(ready3), 32'h1);
    chk("wrap3_addr", ram_addr3, 32'h32);
    chk("wrap3_resp", 32'(rv3), 32'h0);
    v3 = '0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sr_ram_arb.md
SR_RAM_ARB -- requirements
Module: sr_ram_arb

Interface
REQ-001 Parameter PORTS, default 2, number of requesters sharing one local RAM (legal 2..4).
REQ-002 Parameter ADDR_WIDTH, default 32, width of the RAM word address.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  PORTS  per-port request present; held until accepted.
REQ-006 req_we  input  PORTS  per-port 1 = write, 0 = read.
REQ-007 req_addr  input  PORTS*ADDR_WIDTH  per-port word address; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 req_wdata  input  PORTS*32  per-port write data; port i occupies slice [i*32 +: 32].
REQ-009 req_ready  output  PORTS  one-hot accept strobe; a request is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-010 resp_valid  output  PORTS  one-cycle read-response strobe to the port that issued the read.
REQ-011 resp_rdata  output  32  read data; qualified by resp_valid.
REQ-012 ramAddress  output  ADDR_WIDTH  RAM address, registered.
REQ-013 wrData  output  32  RAM write data, registered.
REQ-014 we  output  1  RAM write enable, registered, one-cycle pulse per write.
REQ-015 rdData  input  32  RAM read data; valid the cycle after the address is presented (synchronous read).

Function
REQ-016 FSM states: IDLE, RD_ADDR, RD_DATA; requests are accepted only in IDLE.
REQ-017 req_ready is combinational: in IDLE, it is 1 only for the arbitration winner among asserted req_valid bits; in all other states it is all zeros.
REQ-018 Arbitration is round-robin: search starts at pointer rr_ptr and wraps from PORTS-1 to 0; after an accept, rr_ptr is set to the winner index plus 1, modulo PORTS.
REQ-019 A write accepted in cycle T drives ramAddress, wrData and we=1 in cycle T+1; FSM stays in IDLE, so back-to-back writes sustain one per cycle.
REQ-020 A read accepted in cycle T has the following timing:
- ramAddress = address and we=0 in T+1 (state RD_ADDR).
- State RD_DATA in T+2; rdData is captured at the end of T+2.
- resp_valid[winner]=1 and resp_rdata=captured data in T+3, with FSM back in IDLE.
REQ-021 A new request may be accepted in T+3, the same cycle as the response strobe; read throughput is one read per 3 cycles.
REQ-022 The port index of an outstanding read is held in a register and is not affected by req_valid changes during RD_ADDR or RD_DATA.
REQ-023 we is 0 in every cycle that is not the cycle after a write accept.
REQ-024 ramAddress and wrData hold their last values when idle.
REQ-025 resp_rdata holds its last value between responses.
REQ-026 Requests are serviced in acceptance order, so a write accepted after a read to the same address never affects that read's data.
REQ-027 req_valid deasserted without an accept is legal and has no effect.
REQ-028 At most one resp_valid bit and at most one req_ready bit are ever 1 in any cycle.

Reset
REQ-029 While rst=1 at a clock edge, the following are cleared:
- state to IDLE and rr_ptr to 0;
- we, resp_valid, ramAddress, wrData and resp_rdata to 0.
REQ-030 Reset asserted during RD_ADDR or RD_DATA discards the outstanding read; no resp_valid is produced for it after reset.
REQ-031 req_ready is all zeros in any cycle where rst=1.

Configuration
REQ-032 Macro SR_RAM_ARB_PRIO_EN selects the arbitration scheme.
- Defined: port 0 has fixed highest priority, then ascending index; rr_ptr is unused.
- Undefined: round-robin per REQ-018.

Verification
REQ-033 Single write: port 1 writes addr 0x10, data 0xDEADBEEF.
- Expect req_ready[1] in T, then we=1, ramAddress=0x10, wrData=0xDEADBEEF in T+1.
- Reading 0x10 later returns 0xDEADBEEF.
REQ-034 Contention: ports 0 and 1 both issue continuous writes from reset (round-robin).
- Expect grants alternating 0,1,0,1 on consecutive cycles.
- With SR_RAM_ARB_PRIO_EN defined, expect port 0 on every cycle.
REQ-035 Read latency: port 0 reads addr 0x04 holding 0x12345678.
- Expect resp_valid[0]=1 and resp_rdata=0x12345678 exactly 3 cycles after accept.
- Expect req_ready all zeros in T+1 and T+2.
REQ-036 Read then write to the same address: port 0 reads 0x08 (old 0x1), port 1 writes 0x08 with 0x2.
- Expect the read to return 0x1.
- Expect the write to be accepted in the response cycle, T+3.
REQ-037 Pointer wrap (PORTS=3, all ports requesting writes): expect grant order 0,1,2,0.
REQ-038 Reset mid-read: assert rst in RD_DATA.
- Expect no resp_valid afterwards, state IDLE, and the next grant to go to port 0.
